// File: rtl/aes_cbc_mac_core_if.sv
// Block-stream and control bundle for aes_cbc_mac_core.
// The master side drives messages in; the slave side is the MAC core.
interface aes_cbc_mac_core_if #(parameter int CNT_W = 8);
  logic             start_i;
  logic [CNT_W-1:0] len_i;
  logic [127:0]     key_i;
  logic             abort_i;
  logic             blk_valid_i;
  logic [127:0]     blk_i;
  logic             blk_ready_o;
  logic             tag_valid_o;
  logic [127:0]     tag_o;
  logic             busy_o;
  logic             err_o;

  modport master (
    output start_i, len_i, key_i, abort_i, blk_valid_i, blk_i,
    input  blk_ready_o, tag_valid_o, tag_o, busy_o, err_o
  );

  modport slave (
    input  start_i, len_i, key_i, abort_i, blk_valid_i, blk_i,
    output blk_ready_o, tag_valid_o, tag_o, busy_o, err_o
  );
endinterface

// File: rtl/aes_cbc_mac_core.sv
// Zero-IV AES-128 CBC-MAC, one AES round per cycle with on-the-fly key expansion.
// Optional AES_MAC_LEN_PREPEND_EN: hashes a {zeros, len} block ahead of the message.
//
// state        | meaning
// IDLE         | waiting for start_i
// LEN_BLK      | loading the length block (AES_MAC_LEN_PREPEND_EN only)
// WAIT_BLK     | blk_ready_o high, waiting for the next message block
// INIT_ADD_KEY | initial AddRoundKey, round key register loaded
// ROUNDS       | full rounds 1..9
// FINAL_ROUND  | round 10 (no MixColumns), chain/tag update
module aes_cbc_mac_core #(parameter int CNT_W = 8) (
  input logic clk,
  input logic rst,
  aes_cbc_mac_core_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE, WAIT_BLK, INIT_ADD_KEY, ROUNDS, FINAL_ROUND
`ifdef AES_MAC_LEN_PREPEND_EN
    , LEN_BLK
`endif
  } fsm_e;

  fsm_e             fsm_q;
  logic [127:0]     aes_st_q, chain_q, rk_q, key_q, tag_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       rnd_q;
  logic             tag_valid_q, err_q;
`ifdef AES_MAC_LEN_PREPEND_EN
  logic             len_ph_q;
`endif

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xt(x);
    end
    return p;
  endfunction

  // S-box from first principles: x^254 is the GF(2^8) inverse (0 maps to 0), then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq, inv;
    sq  = x;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
    return o;
  endfunction

  // Byte k lives at [127-8k -: 8]; row r, column c is byte r+4c.
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [31:0] mix_col(input logic [31:0] w);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = w;
    return {xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3,
            xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3)};
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    for (int c = 0; c < 4; c++) o[127-32*c -: 32] = mix_col(s[127-32*c -: 32]);
    return o;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [127:0] key_expand(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] w0, w1, w2, w3, t;
    {w0, w1, w2, w3} = k;
    t  = {sbox(w3[23:16]) ^ rc, sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])};
    w0 = w0 ^ t;
    w1 = w1 ^ w0;
    w2 = w2 ^ w1;
    w3 = w3 ^ w2;
    return {w0, w1, w2, w3};
  endfunction

  logic [127:0] rk_next, sr_st, round_out, final_out;
  assign rk_next   = key_expand(rk_q, rcon(rnd_q));
  assign sr_st     = shift_rows(sub_bytes(aes_st_q));
  assign round_out = mix_columns(sr_st) ^ rk_next;
  assign final_out = sr_st ^ rk_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q       <= IDLE;
      aes_st_q    <= '0;
      chain_q     <= '0;
      rk_q        <= '0;
      key_q       <= '0;
      tag_q       <= '0;
      cnt_q       <= '0;
      rnd_q       <= '0;
      tag_valid_q <= 1'b0;
      err_q       <= 1'b0;
`ifdef AES_MAC_LEN_PREPEND_EN
      len_ph_q    <= 1'b0;
`endif
    end else begin
      tag_valid_q <= 1'b0;
      err_q       <= 1'b0;
      if (fsm_q != IDLE && bus.abort_i) begin
        fsm_q   <= IDLE;
        chain_q <= '0;
`ifdef AES_MAC_LEN_PREPEND_EN
        len_ph_q <= 1'b0;
`endif
      end else begin
        case (fsm_q)
          IDLE: if (bus.start_i) begin
            if (bus.len_i == '0) begin
              err_q <= 1'b1;
            end else begin
              key_q   <= bus.key_i;
              cnt_q   <= bus.len_i;
              chain_q <= '0;
`ifdef AES_MAC_LEN_PREPEND_EN
              fsm_q   <= LEN_BLK;
`else
              fsm_q   <= WAIT_BLK;
`endif
            end
          end
`ifdef AES_MAC_LEN_PREPEND_EN
          LEN_BLK: begin
            aes_st_q <= {{(128-CNT_W){1'b0}}, cnt_q};
            len_ph_q <= 1'b1;
            fsm_q    <= INIT_ADD_KEY;
          end
`endif
          WAIT_BLK: if (bus.blk_valid_i) begin
            aes_st_q <= bus.blk_i ^ chain_q;
            fsm_q    <= INIT_ADD_KEY;
          end
          INIT_ADD_KEY: begin
            aes_st_q <= aes_st_q ^ key_q;
            rk_q     <= key_q;
            rnd_q    <= 4'd1;
            fsm_q    <= ROUNDS;
          end
          ROUNDS: begin
            aes_st_q <= round_out;
            rk_q     <= rk_next;
            rnd_q    <= rnd_q + 4'd1;
            if (rnd_q == 4'd9) fsm_q <= FINAL_ROUND;
          end
          FINAL_ROUND: begin
            aes_st_q <= final_out;
            chain_q  <= final_out;
            rk_q     <= rk_next;
`ifdef AES_MAC_LEN_PREPEND_EN
            if (len_ph_q) begin
              len_ph_q <= 1'b0;
              fsm_q    <= WAIT_BLK;
            end else
`endif
            if (cnt_q == CNT_W'(1)) begin
              tag_q       <= final_out;
              tag_valid_q <= 1'b1;
              fsm_q       <= IDLE;
            end else begin
              cnt_q <= cnt_q - CNT_W'(1);
              fsm_q <= WAIT_BLK;
            end
          end
          default: fsm_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.blk_ready_o = (fsm_q == WAIT_BLK);
  assign bus.busy_o      = (fsm_q != IDLE);
  assign bus.tag_valid_o = tag_valid_q;
  assign bus.tag_o       = tag_q;
  assign bus.err_o       = err_q;

endmodule
